event_generator_unit_v2: RTL



---
 rtl/event_generator_unit_v2.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/event_generator_unit_v2.sv
// Event generator: NUM_CH task/event pairs with per-channel delay counters, PPI publish/subscribe
// and maskable IRQ/NMI outputs, all programmed over the PAR register bus.
module event_generator_unit_v2 #(
  parameter int NUM_CH           = 8,
  parameter int NUM_PPI_CHANNELS = 32,
  parameter int PAR_AW           = 12,
  parameter int PAR_DW           = 32,
  parameter int PAR_WW           = 4,
  parameter int DELAY_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        par_sel,
  input  logic                        par_write,
  input  logic [PAR_AW-1:0]           par_addr,
  input  logic [PAR_DW-1:0]           par_wdata,
  input  logic [PAR_WW-1:0]           par_wstrb,
  output logic [PAR_DW-1:0]           par_rdata,
  input  logic [NUM_PPI_CHANNELS-1:0] ppi_in,
  output logic [NUM_PPI_CHANNELS-1:0] ppi_out,
  output logic                        irq,
  output logic                        nmi
);

  localparam int CW = $clog2(NUM_PPI_CHANNELS);
  localparam int BW = PAR_AW - 7;

  typedef enum logic {
    IDLE,
    COUNT
  } chStateT;

  logic [4:0]    idx;
  logic [BW-1:0] blk;
  logic          wrCycle;
  logic          rdCycle;
  logic          hitTask, hitSub, hitEvent, hitPub, hitDelay, hitIntr;

  logic [PAR_DW-1:0] byteMask;
  logic [PAR_DW-1:0] wdataMasked;

  logic [NUM_CH-1:0] taskWr, subWr, eventWr, pubWr, delayWr;
  logic intEnWr, intSetWr, intClrWr, nmiEnWr, nmiSetWr, nmiClrWr;

  logic [CW-1:0]      subCh    [NUM_CH];
  logic [NUM_CH-1:0]  subEn;
  logic [CW-1:0]      pubCh    [NUM_CH];
  logic [NUM_CH-1:0]  pubEn;
  logic [DELAY_W-1:0] delayReg [NUM_CH];
  logic [NUM_CH-1:0]  eventFlag;
  logic [NUM_CH-1:0]  intEn;
  logic [NUM_CH-1:0]  nmiEn;

  chStateT            chState     [NUM_CH];
  chStateT            chStateNext [NUM_CH];
  logic [DELAY_W-1:0] cnt         [NUM_CH];
  logic [DELAY_W-1:0] cntNext     [NUM_CH];
  logic [NUM_CH-1:0]  trigger;
  logic [NUM_CH-1:0]  genPulse;

  logic [NUM_PPI_CHANNELS-1:0] pubNext;
  logic [PAR_DW-1:0]           readData;
  logic                        unusedBits;

  // The register map is split into 128-byte blocks of 32 word slots each.
  assign idx      = par_addr[6:2];
  assign blk      = par_addr[PAR_AW-1:7];
  assign wrCycle  = par_sel & par_write;
  assign rdCycle  = par_sel & ~par_write;
  assign hitTask  = (blk == BW'(0));
  assign hitSub   = (blk == BW'(1));
  assign hitEvent = (blk == BW'(2));
  assign hitPub   = (blk == BW'(3));
  assign hitDelay = (blk == BW'(4));
  assign hitIntr  = (blk == BW'(6));

  assign intEnWr  = wrCycle & hitIntr & (idx == 5'd0);
  assign intSetWr = wrCycle & hitIntr & (idx == 5'd1);
  assign intClrWr = wrCycle & hitIntr & (idx == 5'd2);
  assign nmiEnWr  = wrCycle & hitIntr & (idx == 5'd8);
  assign nmiSetWr = wrCycle & hitIntr & (idx == 5'd9);
  assign nmiClrWr = wrCycle & hitIntr & (idx == 5'd10);

  always_comb begin
    byteMask = '0;
    for (int b = 0; b < PAR_WW; b++) begin
      byteMask[8*b +: 8] = {8{par_wstrb[b]}};
    end
    wdataMasked = par_wdata & byteMask;
  end

  // Per-channel write decode; slots at or beyond NUM_CH never match.
  always_comb begin
    taskWr  = '0;
    subWr   = '0;
    eventWr = '0;
    pubWr   = '0;
    delayWr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wrCycle && (idx == 5'(i))) begin
        taskWr[i]  = hitTask;
        subWr[i]   = hitSub;
        eventWr[i] = hitEvent;
        pubWr[i]   = hitPub;
        delayWr[i] = hitDelay;
      end
    end
  end

  always_comb begin
    trigger = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      trigger[i] = (taskWr[i] & par_wdata[0] & par_wstrb[0]) | (subEn[i] & ppi_in[subCh[i]]);
    end
  end

  // Channel FSM: a retrigger in COUNT reloads from the current DELAY value.
  always_comb begin
    genPulse = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chStateNext[i] = chState[i];
      cntNext[i]     = cnt[i];
      case (chState[i])
        IDLE: begin
          if (trigger[i]) begin
            if (delayReg[i] == '0) begin
              genPulse[i] = 1'b1;
            end else begin
              chStateNext[i] = COUNT;
              cntNext[i]     = delayReg[i];
            end
          end
        end
        COUNT: begin
          if (trigger[i]) begin
            if (delayReg[i] == '0) begin
              genPulse[i]    = 1'b1;
              chStateNext[i] = IDLE;
              cntNext[i]     = '0;
            end else begin
              cntNext[i] = delayReg[i];
            end
          end else if (cnt[i] == DELAY_W'(1)) begin
            genPulse[i]    = 1'b1;
            chStateNext[i] = IDLE;
            cntNext[i]     = '0;
          end else begin
            cntNext[i] = cnt[i] - DELAY_W'(1);
          end
        end
        default: begin
          chStateNext[i] = IDLE;
          cntNext[i]     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chState[i] <= IDLE;
        cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        chState[i] <= chStateNext[i];
        cnt[i]     <= cntNext[i];
      end
    end
  end

  // Configuration registers honour byte strobes; the enable bit lives in the top byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        subCh[i]    <= '0;
        pubCh[i]    <= '0;
        delayReg[i] <= '0;
      end
      subEn <= '0;
      pubEn <= '0;
      intEn <= '0;
      nmiEn <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (subWr[i]) begin
          subCh[i] <= (subCh[i] & ~byteMask[CW-1:0]) | wdataMasked[CW-1:0];
          if (byteMask[PAR_DW-1]) subEn[i] <= par_wdata[PAR_DW-1];
        end
        if (pubWr[i]) begin
          pubCh[i] <= (pubCh[i] & ~byteMask[CW-1:0]) | wdataMasked[CW-1:0];
          if (byteMask[PAR_DW-1]) pubEn[i] <= par_wdata[PAR_DW-1];
        end
        if (delayWr[i]) begin
          delayReg[i] <= (delayReg[i] & ~byteMask[DELAY_W-1:0]) | wdataMasked[DELAY_W-1:0];
        end
      end
      if (intEnWr) begin
        intEn <= (intEn & ~byteMask[NUM_CH-1:0]) | wdataMasked[NUM_CH-1:0];
      end else if (intSetWr) begin
        intEn <= intEn | wdataMasked[NUM_CH-1:0];
      end else if (intClrWr) begin
        intEn <= intEn & ~wdataMasked[NUM_CH-1:0];
      end
      if (nmiEnWr) begin
        nmiEn <= (nmiEn & ~byteMask[NUM_CH-1:0]) | wdataMasked[NUM_CH-1:0];
      end else if (nmiSetWr) begin
        nmiEn <= nmiEn | wdataMasked[NUM_CH-1:0];
      end else if (nmiClrWr) begin
        nmiEn <= nmiEn & ~wdataMasked[NUM_CH-1:0];
      end
    end
  end

  // A new generation beats a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eventFlag <= '0;
    end else begin
      eventFlag <= genPulse | (eventFlag & ~(eventWr & {NUM_CH{~par_wdata[0]}}));
    end
  end

  always_comb begin
    pubNext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (genPulse[i] && pubEn[i]) begin
        pubNext = pubNext | (NUM_PPI_CHANNELS'(1) << pubCh[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ppi_out <= '0;
    end else begin
      ppi_out <= pubNext;
    end
  end

  always_comb begin
    readData = '0;
    if (hitIntr) begin
      if ((idx == 5'd0) || (idx == 5'd1) || (idx == 5'd2)) begin
        readData[NUM_CH-1:0] = intEn;
      end else if ((idx == 5'd8) || (idx == 5'd9) || (idx == 5'd10)) begin
        readData[NUM_CH-1:0] = nmiEn;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (idx == 5'(i)) begin
          if (hitSub) begin
            readData[CW-1:0]   = subCh[i];
            readData[PAR_DW-1] = subEn[i];
          end else if (hitPub) begin
            readData[CW-1:0]   = pubCh[i];
            readData[PAR_DW-1] = pubEn[i];
          end else if (hitEvent) begin
            readData[0] = eventFlag[i];
          end else if (hitDelay) begin
            readData[DELAY_W-1:0] = delayReg[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_rdata <= '0;
    end else if (rdCycle) begin
      par_rdata <= readData;
    end
  end

  assign irq = |(eventFlag & intEn);
  assign nmi = |(eventFlag & nmiEn);

  assign unusedBits = ^{par_addr[1:0], wdataMasked, byteMask};

endmodule
